// File: rtl/lab6_ctrl_pkg.sv
// lab6_ctrl_pkg: shared state encoding and widths for the lab 6 fetch controller
package lab6_ctrl_pkg;
  typedef enum logic [2:0] {
    HALTED = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    FETCH3 = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } state_t;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/fetch_controller.sv
// fetch_controller: Moore FSM sequencing MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR with operator pause
module fetch_controller
  import lab6_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  output logic             GatePC,
  output logic             GateMDR,
  output logic             GateMARMUX,
  output logic             LD_MAR,
  output logic             LD_PC,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic             MIO_EN,
  output logic             Mem_CE,
  output logic             Mem_OE,
  output logic             Mem_WE,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Fetch_Count
);
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_WAIT);
  state_t state;
  logic [WAIT_W-1:0] wcnt;
  // state, SRAM wait counter and completed-fetch counter; PAUSE1/PAUSE2 pair turns a held Continue into one fetch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      wcnt <= '0;
      Fetch_Count <= '0;
    end else begin
      case (state)
        HALTED: state <= Run ? FETCH1 : HALTED;
        FETCH1: begin
          state <= FETCH2;
          wcnt <= '0;
        end
        FETCH2: begin
          state <= (wcnt == LAST) ? FETCH3 : FETCH2;
          wcnt <= wcnt + 1'b1;
        end
        FETCH3: begin
          state <= PAUSE1;
          Fetch_Count <= Fetch_Count + 1'b1;
        end
        PAUSE1: state <= Continue ? PAUSE2 : PAUSE1;
        PAUSE2: state <= Continue ? PAUSE2 : FETCH1;
        default: state <= HALTED;
      endcase
    end
  end
  assign GatePC = state == FETCH1;
  assign LD_MAR = state == FETCH1;
  assign LD_PC = state == FETCH1;
  assign GateMDR = state == FETCH3;
  assign LD_IR = state == FETCH3;
  assign GateMARMUX = 1'b0;
  assign MIO_EN = state == FETCH2;
  assign LD_MDR = state == FETCH2 && wcnt == LAST;
  assign Mem_CE = state != FETCH2;
  assign Mem_OE = state != FETCH2;
  assign Mem_WE = 1'b1;
  assign State = state;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vector table plus hand sequences for fetch_controller
module tb_fetch_controller;
  localparam logic [10:0] IDLE = 11'b00000000111;
  localparam logic [10:0] F1   = 11'b10011000111;
  localparam logic [10:0] F2W  = 11'b00000001001;
  localparam logic [10:0] F2L  = 11'b00000101001;
  localparam logic [10:0] F3   = 11'b01000010111;

  typedef struct {
    logic       rst;
    logic       run;
    logic       cont;
    logic [2:0] st;
    logic [10:0] ctl;
    logic [3:0] cnt;
  } vec_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic a_rst, a_run, a_cont;
  logic a_gpc, a_gmdr, a_gmm, a_ldmar, a_ldpc, a_ldmdr, a_ldir, a_mio, a_ce, a_oe, a_we;
  logic [2:0] a_st;
  logic [3:0] a_cnt;
  logic [10:0] a_ctl;
  assign a_ctl = {a_gpc, a_gmdr, a_gmm, a_ldmar, a_ldpc, a_ldmdr, a_ldir, a_mio, a_ce, a_oe, a_we};

  fetch_controller #(.MEM_WAIT(1), .CNT_W(4)) u_a (
    .Clk(Clk), .Reset(a_rst), .Run(a_run), .Continue(a_cont),
    .GatePC(a_gpc), .GateMDR(a_gmdr), .GateMARMUX(a_gmm), .LD_MAR(a_ldmar), .LD_PC(a_ldpc),
    .LD_MDR(a_ldmdr), .LD_IR(a_ldir), .MIO_EN(a_mio), .Mem_CE(a_ce), .Mem_OE(a_oe), .Mem_WE(a_we),
    .State(a_st), .Fetch_Count(a_cnt)
  );

  logic b_rst, b_run, b_cont;
  logic b_gpc, b_gmdr, b_gmm, b_ldmar, b_ldpc, b_ldmdr, b_ldir, b_mio, b_ce, b_oe, b_we;
  logic c_gpc, c_gmdr, c_gmm, c_ldmar, c_ldpc, c_ldmdr, c_ldir, c_mio, c_ce, c_oe, c_we;
  logic [2:0] b_st, c_st;
  logic [15:0] b_cnt, c_cnt;

  fetch_controller #(.MEM_WAIT(0), .CNT_W(16)) u_b (
    .Clk(Clk), .Reset(b_rst), .Run(b_run), .Continue(b_cont),
    .GatePC(b_gpc), .GateMDR(b_gmdr), .GateMARMUX(b_gmm), .LD_MAR(b_ldmar), .LD_PC(b_ldpc),
    .LD_MDR(b_ldmdr), .LD_IR(b_ldir), .MIO_EN(b_mio), .Mem_CE(b_ce), .Mem_OE(b_oe), .Mem_WE(b_we),
    .State(b_st), .Fetch_Count(b_cnt)
  );

  fetch_controller #(.MEM_WAIT(3), .CNT_W(16)) u_c (
    .Clk(Clk), .Reset(b_rst), .Run(b_run), .Continue(b_cont),
    .GatePC(c_gpc), .GateMDR(c_gmdr), .GateMARMUX(c_gmm), .LD_MAR(c_ldmar), .LD_PC(c_ldpc),
    .LD_MDR(c_ldmdr), .LD_IR(c_ldir), .MIO_EN(c_mio), .Mem_CE(c_ce), .Mem_OE(c_oe), .Mem_WE(c_we),
    .State(c_st), .Fetch_Count(c_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic rst, input logic run, input logic cont);
    a_rst = rst;
    a_run = run;
    a_cont = cont;
    @(posedge Clk);
    #1;
  endtask

  vec_t tv[18];

  initial begin
    int bir, cir, bmdr, cmdr, bf2, cf2;
    a_rst = 1'b1; a_run = 1'b0; a_cont = 1'b0;
    b_rst = 1'b1; b_run = 1'b0; b_cont = 1'b0;
    tv[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, IDLE, 4'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 3'd0, IDLE, 4'd0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, IDLE, 4'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 3'd0, IDLE, 4'd0};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 3'd1, F1,   4'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 3'd2, F2W,  4'd0};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 3'd2, F2L,  4'd0};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 3'd3, F3,   4'd0};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 3'd4, IDLE, 4'd1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 3'd4, IDLE, 4'd1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 3'd5, IDLE, 4'd1};
    tv[11] = '{1'b0, 1'b0, 1'b1, 3'd5, IDLE, 4'd1};
    tv[12] = '{1'b0, 1'b1, 1'b1, 3'd5, IDLE, 4'd1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 3'd1, F1,   4'd1};
    tv[14] = '{1'b0, 1'b0, 1'b0, 3'd2, F2W,  4'd1};
    tv[15] = '{1'b0, 1'b0, 1'b0, 3'd2, F2L,  4'd1};
    tv[16] = '{1'b0, 1'b0, 1'b0, 3'd3, F3,   4'd1};
    tv[17] = '{1'b0, 1'b0, 1'b0, 3'd4, IDLE, 4'd2};
    #1;
    for (int i = 0; i < 18; i++) begin
      step_a(tv[i].rst, tv[i].run, tv[i].cont);
      chk($sformatf("vec%0d_state", i), 32'(a_st), 32'(tv[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(a_ctl), 32'(tv[i].ctl));
      chk($sformatf("vec%0d_count", i), 32'(a_cnt), 32'(tv[i].cnt));
    end
    for (int i = 2; i < 16; i++) begin
      step_a(1'b0, 1'b0, 1'b1);
      step_a(1'b0, 1'b0, 1'b0);
      repeat (4) step_a(1'b0, 1'b0, 1'b0);
      chk($sformatf("wrap%0d_state", i), 32'(a_st), 32'd4);
      chk($sformatf("wrap%0d_count", i), 32'(a_cnt), 32'((i + 1) % 16));
    end
    step_a(1'b0, 1'b0, 1'b1);
    step_a(1'b0, 1'b0, 1'b0);
    chk("abort_f1_state", 32'(a_st), 32'd1);
    step_a(1'b0, 1'b0, 1'b0);
    chk("abort_f2_ctl", 32'(a_ctl), 32'(F2W));
    step_a(1'b1, 1'b0, 1'b0);
    chk("abort_state", 32'(a_st), 32'd0);
    chk("abort_ctl", 32'(a_ctl), 32'(IDLE));
    chk("abort_count", 32'(a_cnt), 32'd0);
    step_a(1'b0, 1'b0, 1'b0);
    chk("abort_hold_state", 32'(a_st), 32'd0);

    repeat (2) @(posedge Clk);
    #1;
    b_rst = 1'b0;
    bir = 0; cir = 0; bmdr = 0; cmdr = 0; bf2 = 0; cf2 = 0;
    for (int k = 1; k <= 12; k++) begin
      b_run = (k == 1);
      @(posedge Clk);
      #1;
      if (b_ldir && bir == 0) bir = k;
      if (c_ldir && cir == 0) cir = k;
      if (b_ldmdr) bmdr++;
      if (c_ldmdr) cmdr++;
      if (b_st == 3'd2) bf2++;
      if (c_st == 3'd2) cf2++;
    end
    chk("w0_ldir_cycle", 32'(bir), 32'd3);
    chk("w3_ldir_cycle", 32'(cir), 32'd6);
    chk("w0_fetch2_cycles", 32'(bf2), 32'd1);
    chk("w3_fetch2_cycles", 32'(cf2), 32'd4);
    chk("w0_ldmdr_pulses", 32'(bmdr), 32'd1);
    chk("w3_ldmdr_pulses", 32'(cmdr), 32'd1);
    chk("w0_final_state", 32'(b_st), 32'd4);
    chk("w3_final_count", 32'(c_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Moore FSM that sequences the lab 6 fetch datapath. It drives the gate, load and MIO controls, plus active-low SRAM strobes, to run MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR. After each fetch it pauses so the operator can inspect IR. It sits between the top-level switches/buttons and the datapath register/bus module, and counts completed fetches.

Parameters:
MEM_WAIT, 1, extra SRAM read wait cycles before MDR load; legal range 0..15.
CNT_W, 16, width of the completed-fetch counter.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Run  input  1  active-high level; starts fetching from HALTED.
Continue  input  1  active-high level; releases PAUSE.
GatePC  output  1  drive PC onto bus.
GateMDR  output  1  drive MDR onto bus.
GateMARMUX  output  1  tied 0 in this block (no address adder yet).
LD_MAR  output  1  load MAR from bus.
LD_PC  output  1  load PC with PC+1.
LD_MDR  output  1  load MDR.
LD_IR  output  1  load IR from bus.
MIO_EN  output  1  MDR mux selects memory data.
Mem_CE  output  1  SRAM chip enable, active-low.
Mem_OE  output  1  SRAM output enable, active-low.
Mem_WE  output  1  SRAM write enable, active-low; always 1 (read-only fetch).
State  output  3  current state encoding, for debug/hex display.
Fetch_Count  output  CNT_W  number of completed fetches.

Behaviour:
- Reset (sampled at edge):
  - State=HALTED, wait counter=0, Fetch_Count=0.
  - All active-high controls 0; Mem_CE/Mem_OE/Mem_WE=1.
  - Reset overrides every other input and aborts any fetch in progress, including mid-wait.
- Outputs are pure decodes of the registered state and wait counter. No input-to-output combinational path.
- HALTED (0): all controls idle. Run=1 -> FETCH1 next edge. Otherwise stay.
- FETCH1 (1): GatePC=1, LD_MAR=1, LD_PC=1 for exactly one cycle. The datapath loads MAR and increments PC on the same edge. Next state FETCH2; wait counter cleared to 0.
- FETCH2 (2): lasts MEM_WAIT+1 cycles.
  - Mem_CE=0, Mem_OE=0, MIO_EN=1 throughout.
  - Wait counter increments each cycle.
  - LD_MDR=1 only in the final cycle (counter==MEM_WAIT).
  - With MEM_WAIT=0, FETCH2 is one cycle with LD_MDR=1.
  - Then -> FETCH3.
- FETCH3 (3): GateMDR=1, LD_IR=1 for one cycle. Fetch_Count increments, wrapping from all-ones to 0. -> PAUSE1.
- PAUSE1 (4): idle. Continue=1 -> PAUSE2, else stay.
- PAUSE2 (5): idle. Continue=0 -> FETCH1, else stay. This is release detection: a held button yields exactly one fetch.
- Run is ignored outside HALTED. Continue is ignored outside PAUSE1/PAUSE2.
- If Run and Continue are both high in HALTED, go to FETCH1 (Continue is don't-care).
- Unused encodings 6,7 -> HALTED next edge with idle outputs.
- Invariant: at most one of GatePC/GateMDR/GateMARMUX is high in any cycle.
- Invariant: MIO_EN=1 only in FETCH2.
- Fetch latency from leaving HALTED/PAUSE2 to the LD_IR cycle: MEM_WAIT+3 cycles.

Decomposition:
- Shared package lab6_ctrl_pkg holds:
  - state_t enum (HALTED=0, FETCH1=1, FETCH2=2, FETCH3=3, PAUSE1=4, PAUSE2=5), 3-bit.
  - Localparam WAIT_W=4.
- No sub-module. The wait counter and fetch counter stay inline.
- Top level instantiates fetch_controller alongside datapath and wires the control outputs port-to-port.

Test Plan:
1. Reset=1 for 2 cycles, then 0 with Run=0 -> State=0, all controls 0, Mem_CE/OE/WE=1, Fetch_Count=0, held indefinitely.
2. MEM_WAIT=1, PC=0x0000, M[0]=0x1234, Run pulse 1 cycle -> cycle 1 FETCH1 (GatePC, LD_MAR, LD_PC); cycles 2-3 FETCH2 with LD_MDR only in cycle 3; cycle 4 LD_IR; then IR=0x1234, PC=0x0001, Fetch_Count=1, State=4.
3. From PAUSE1, hold Continue=1 for 10 cycles then release -> exactly one further fetch; IR=M[1], PC=0x0002, Fetch_Count=2; State stays 5 while held.
4. MEM_WAIT=0 -> FETCH2 lasts one cycle with LD_MDR=1; Run-to-LD_IR is 3 cycles.
5. Assert Reset during the first FETCH2 cycle with MEM_WAIT=3 -> next cycle State=0, Mem_OE=1, MIO_EN=0, LD_MDR never asserted; Fetch_Count=0.
6. Preload Fetch_Count via 2^CNT_W fetches (or CNT_W=4 build, 16 fetches) -> wraps to 0. Run=1 asserted during PAUSE1 -> no state change.
